serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: streams operands LSB first through an external
// full adder, one bit per clock, and returns the registered sum and carry.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_c;

  // Final serial step: this edge processes the operand MSB.
  assign last_c = (cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus status and full-adder drive decoded from the state.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    fa_a    = 1'b0;
    fa_b    = 1'b0;
    fa_ci   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        fa_a  = a_sh[0];
        fa_b  = b_sh[0];
        fa_ci = carry;
        if (last_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture, serial shifting and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            s_sh  <= '0;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= {fa_s, s_sh[WIDTH-1:1]};
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          if (last_c) begin
            sum  <= {fa_s, s_sh[WIDTH-1:1]};
            cout <= fa_co;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) with a behavioural full
// adder on the fa_* ports and an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         fa_a;
  logic         fa_b;
  logic         fa_ci;
  logic         fa_s;
  logic         fa_co;

  int tests_run;
  int tests_failed;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .fa_a  (fa_a),
    .fa_b  (fa_b),
    .fa_ci (fa_ci),
    .fa_s  (fa_s),
    .fa_co (fa_co)
  );

  // Team full adder.
  assign {fa_co, fa_s} = {1'b0, fa_a} + {1'b0, fa_b} + {1'b0, fa_ci};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one op and observe 14 cycles after the accepting edge. Optionally
  // scramble a/b/cin/start while the op is in flight.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                       input bit perturb,
                       output logic [W-1:0] rs, output logic rc, output int lat,
                       output int bcnt, output int dcnt, output int early, output int faerr);
    logic [W-1:0] s0;
    logic [W:0]   m;
    logic [W:0]   t;
    s0    = sum;
    rs    = sum;
    rc    = cout;
    lat   = -1;
    bcnt  = 0;
    dcnt  = 0;
    early = 0;
    faerr = 0;
    a     = oa;
    b     = ob;
    cin   = oc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (busy) begin
        bcnt++;
        if (k < int'(W)) begin
          m = (9'd1 << k) - 9'd1;
          t = ({1'b0, oa} & m) + ({1'b0, ob} & m) + 9'(oc);
          if ({fa_a, fa_b, fa_ci} !== {oa[k], ob[k], t[k]}) faerr++;
        end
      end else if ({fa_a, fa_b, fa_ci} !== 3'b000) begin
        faerr++;
      end
      if (done) begin
        dcnt++;
        if (lat < 0) begin
          lat = k;
          rs  = sum;
          rc  = cout;
        end
      end
      if (k < int'(W) && sum !== s0) early++;
      if (perturb && busy && k < 7) begin
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        start = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #3;
    tests_run++;
    if ({busy, done, sum, cout, fa_a, fa_b, fa_ci} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b fa=%b%b%b, want all 0",
               busy, done, sum, cout, fa_a, fa_b, fa_ci);
    end
    #20;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({busy, done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_vectors;
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic         vc [4];
    logic [W-1:0] rs;
    logic         rc;
    logic [W:0]   exp;
    int lat, bcnt, dcnt, early, faerr;
    va = '{8'h00, 8'hFF, 8'h3C, 8'hFF};
    vb = '{8'h00, 8'h01, 8'h42, 8'hFF};
    vc = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], vc[i], 1'b0, rs, rc, lat, bcnt, dcnt, early, faerr);
      exp = {1'b0, va[i]} + {1'b0, vb[i]} + 9'(vc[i]);
      tests_run++;
      if ({rc, rs} !== exp) begin
        tests_failed++;
        $display("FAIL vec%0d_result: got %b_%h, want %b_%h", i, rc, rs, exp[W], exp[W-1:0]);
      end
      tests_run++;
      if (lat != int'(W) || bcnt != int'(W) || dcnt != 1) begin
        tests_failed++;
        $display("FAIL vec%0d_timing: got lat=%0d busy=%0d done=%0d, want 8 8 1", i, lat, bcnt, dcnt);
      end
      tests_run++;
      if (early != 0 || faerr != 0) begin
        tests_failed++;
        $display("FAIL vec%0d_serial: got early=%0d fa_err=%0d, want 0 0", i, early, faerr);
      end
    end
  endtask

  task automatic test_input_changes;
    logic [W-1:0] rs;
    logic         rc;
    int lat, bcnt, dcnt, early, faerr;
    do_op(8'hA5, 8'h5A, 1'b1, 1'b1, rs, rc, lat, bcnt, dcnt, early, faerr);
    tests_run++;
    if ({rc, rs} !== 9'h100) begin
      tests_failed++;
      $display("FAIL hold_result: got %b_%h, want 1_00", rc, rs);
    end
    tests_run++;
    if (dcnt != 1 || lat != int'(W) || bcnt != int'(W) || faerr != 0) begin
      tests_failed++;
      $display("FAIL hold_timing: got done=%0d lat=%0d busy=%0d fa_err=%0d, want 1 8 8 0",
               dcnt, lat, bcnt, faerr);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] oa [3];
    logic [W-1:0] ob [3];
    logic [W-1:0] ds [3];
    logic         dc [3];
    int           dt [3];
    logic [W:0]   exp;
    logic         prev_busy;
    int           acc;
    int           nd;
    oa = '{8'h01, 8'h80, 8'hFF};
    ob = '{8'h01, 8'h80, 8'hFF};
    acc = 0;
    nd  = 0;
    a     = oa[0];
    b     = ob[0];
    cin   = 1'b0;
    start = 1'b1;
    prev_busy = busy;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (busy && !prev_busy) begin
        acc++;
        if (acc < 3) begin
          a = oa[acc];
          b = ob[acc];
        end else begin
          a     = W'($urandom);
          b     = W'($urandom);
          start = 1'b0;
        end
      end
      if (done) begin
        if (nd < 3) begin
          dt[nd] = c;
          ds[nd] = sum;
          dc[nd] = cout;
        end
        nd++;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    tests_run++;
    if (nd != 3) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d done pulses, want 3", nd);
    end else begin
      for (int i = 0; i < 3; i++) begin
        exp = {1'b0, oa[i]} + {1'b0, ob[i]};
        tests_run++;
        if ({dc[i], ds[i]} !== exp) begin
          tests_failed++;
          $display("FAIL b2b_result%0d: got %b_%h, want %b_%h", i, dc[i], ds[i], exp[W], exp[W-1:0]);
        end
      end
      tests_run++;
      if (dt[1] - dt[0] != int'(W) + 2 || dt[2] - dt[1] != int'(W) + 2) begin
        tests_failed++;
        $display("FAIL b2b_spacing: got %0d and %0d, want 10 and 10", dt[1] - dt[0], dt[2] - dt[1]);
      end
    end
  endtask

  task automatic test_mid_reset;
    logic [W-1:0] rs;
    logic         rc;
    int lat, bcnt, dcnt, early, faerr;
    int seen_done;
    a     = 8'h12;
    b     = 8'h34;
    cin   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, sum, cout, fa_a, fa_b, fa_ci} !== '0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: got busy=%b done=%b sum=%h cout=%b fa=%b%b%b, want all 0",
               busy, done, sum, cout, fa_a, fa_b, fa_ci);
    end
    seen_done = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    #2;
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (seen_done != 0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_nodone: got %0d done pulses, want 0", seen_done);
    end
    do_op(8'h10, 8'h20, 1'b0, 1'b0, rs, rc, lat, bcnt, dcnt, early, faerr);
    tests_run++;
    if ({rc, rs} !== 9'h030 || lat != int'(W) || dcnt != 1) begin
      tests_failed++;
      $display("FAIL midrst_next: got %b_%h lat=%0d done=%0d, want 0_30 8 1", rc, rs, lat, dcnt);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rcin;
    logic [W-1:0] rs;
    logic         rc;
    logic [W:0]   exp;
    int lat, bcnt, dcnt, early, faerr;
    for (int i = 0; i < 25; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rcin = 1'($urandom);
      do_op(ra, rb, rcin, 1'($urandom), rs, rc, lat, bcnt, dcnt, early, faerr);
      exp = {1'b0, ra} + {1'b0, rb} + 9'(rcin);
      tests_run++;
      if ({rc, rs} !== exp || lat != int'(W) || bcnt != int'(W) || dcnt != 1 ||
          early != 0 || faerr != 0) begin
        tests_failed++;
        $display("FAIL rand%0d: %h+%h+%b got %b_%h lat=%0d busy=%0d done=%0d early=%0d fa_err=%0d, want %b_%h 8 8 1 0 0",
                 i, ra, rb, rcin, rc, rs, lat, bcnt, dcnt, early, faerr, exp[W], exp[W-1:0]);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_vectors();
    test_input_changes();
    test_back_to_back();
    @(posedge clk); #1;
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
